// File: rtl/spare_remap_ctrl.sv
// spare_remap_ctrl: repair table for faulty 128-byte blocks and request
// translation onto the 25-bank spare SRAM array.
// Fault handshake: a report transfers on a rising CLK edge where
// FAULT_VLD & FAULT_RDY are both 1; FAULT_VLD may drop without a transfer,
// and FAULT_RDY never depends on FAULT_VLD.
module spare_remap_ctrl #(
  parameter int ADDR_W = 15,
  parameter int NSPARE = 25
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CLR_TABLE,
  input  logic              FAULT_VLD,
  input  logic [ADDR_W-1:0] FAULT_ADDR,
  output logic              FAULT_RDY,
  input  logic              REQ_VLD,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic              REQ_WEB,
  input  logic [7:0]        REQ_IDATA,
  output logic              SPARE_HIT,
  output logic              RD_SPARE_VLD,
  output logic [4:0]        USED_CNT,
  output logic              REPAIR_FAIL,
  output logic [6:0]        MEM_ADDR,
  output logic              MEM_WEB,
  output logic [NSPARE-1:0] MEM_CSB,
  output logic [NSPARE-1:0] MEM_OEB,
  output logic [7:0]        MEM_IDATA,
  output logic [4:0]        MEM_ODATA_SELECT,
  output logic              dbg_state
);

  localparam int BLK_W = ADDR_W - 7;
  localparam int SEL_W = 5;
  localparam logic [NSPARE-1:0] ONE_HOT0 = {{(NSPARE-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE = 1'b0, S_CHECK = 1'b1} state_t;

  state_t             state, state_nxt;
  logic               armed;
  logic [BLK_W-1:0]   fault_blk;
  logic [BLK_W-1:0]   tab_blk [NSPARE];
  logic [NSPARE-1:0]  tab_vld;
  logic               chk_match, chk_write, chk_fail, table_full;
  logic               req_match, issue_hit;
  logic [SEL_W-1:0]   req_idx, issue_idx;
  logic               issue_rd;
  logic               fault_acc;
  logic               unused_ok;

  // Offset bits of a fault report are irrelevant: repair granularity is a block.
  assign unused_ok  = ^FAULT_ADDR[6:0];
  assign fault_acc  = FAULT_VLD & FAULT_RDY;
  assign table_full = (USED_CNT == SEL_W'(NSPARE));
  assign issue_hit  = REQ_VLD & req_match;
  // A read is in its data stage exactly when the previous issue was a read hit.
  assign issue_rd   = SPARE_HIT & MEM_WEB;

  // Compare the latched fault block against every allocated entry.
  always_comb begin
    chk_match = 1'b0;
    for (int i = 0; i < NSPARE; i++) begin
      if (tab_vld[i] && (tab_blk[i] == fault_blk)) chk_match = 1'b1;
    end
  end

  // Request lookup; entries are unique so at most one index matches.
  always_comb begin
    req_match = 1'b0;
    req_idx   = '0;
    for (int i = 0; i < NSPARE; i++) begin
      if (tab_vld[i] && (tab_blk[i] == REQ_ADDR[ADDR_W-1:7])) begin
        req_match = 1'b1;
        req_idx   = SEL_W'(i);
      end
    end
  end

  // Fault FSM state register; armed keeps FAULT_RDY low until the first edge after reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // Fault FSM next state; a table clear abandons any report in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fault_acc) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (CLR_TABLE) state_nxt = S_IDLE;
  end

  // Fault FSM outputs: ready in IDLE, table update decisions in CHECK.
  always_comb begin
    FAULT_RDY = armed & (state == S_IDLE);
    dbg_state = state;
    chk_write = (state == S_CHECK) & ~CLR_TABLE & ~chk_match & ~table_full;
    chk_fail  = (state == S_CHECK) & ~CLR_TABLE & ~chk_match &  table_full;
  end

  // Latch the block of an accepted report for the CHECK cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)          fault_blk <= '0;
    else if (fault_acc) fault_blk <= FAULT_ADDR[ADDR_W-1:7];
  end

  // Repair table, allocation counter and sticky overflow flag.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tab_vld     <= '0;
      USED_CNT    <= '0;
      REPAIR_FAIL <= 1'b0;
      for (int i = 0; i < NSPARE; i++) tab_blk[i] <= '0;
    end else if (CLR_TABLE) begin
      tab_vld     <= '0;
      USED_CNT    <= '0;
      REPAIR_FAIL <= 1'b0;
    end else if (chk_write) begin
      tab_vld[USED_CNT] <= 1'b1;
      tab_blk[USED_CNT] <= fault_blk;
      USED_CNT          <= USED_CNT + 1'b1;
    end else if (chk_fail) begin
      REPAIR_FAIL <= 1'b1;
    end
  end

  // Issue stage: chip-select, address, write data for a hit; idle strobes otherwise.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      MEM_CSB   <= '1;
      MEM_WEB   <= 1'b1;
      MEM_ADDR  <= '0;
      MEM_IDATA <= '0;
      SPARE_HIT <= 1'b0;
      issue_idx <= '0;
    end else if (issue_hit) begin
      MEM_CSB   <= ~(ONE_HOT0 << req_idx);
      MEM_WEB   <= REQ_WEB;
      MEM_ADDR  <= REQ_ADDR[6:0];
      MEM_IDATA <= REQ_IDATA;
      SPARE_HIT <= 1'b1;
      issue_idx <= req_idx;
    end else begin
      MEM_CSB   <= '1;
      MEM_WEB   <= 1'b1;
      SPARE_HIT <= 1'b0;
    end
  end

  // Data stage: output enable and read-mux select one cycle after a read issue.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      MEM_OEB          <= '1;
      MEM_ODATA_SELECT <= '0;
      RD_SPARE_VLD     <= 1'b0;
    end else if (issue_rd) begin
      MEM_OEB          <= ~(ONE_HOT0 << issue_idx);
      MEM_ODATA_SELECT <= issue_idx;
      RD_SPARE_VLD     <= 1'b1;
    end else begin
      MEM_OEB          <= '1;
      RD_SPARE_VLD     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spare_remap_ctrl.sv
// Bench for spare_remap_ctrl: directed scenarios plus a randomized phase,
// checked against a queue-based table model and a behavioural spare array.
module tb_spare_remap_ctrl;

  localparam int ADDR_W = 15;
  localparam int NS     = 25;

  logic              CLK;
  logic              RSTN;
  logic              CLR_TABLE;
  logic              FAULT_VLD;
  logic [ADDR_W-1:0] FAULT_ADDR;
  logic              FAULT_RDY;
  logic              REQ_VLD;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic              REQ_WEB;
  logic [7:0]        REQ_IDATA;
  logic              SPARE_HIT;
  logic              RD_SPARE_VLD;
  logic [4:0]        USED_CNT;
  logic              REPAIR_FAIL;
  logic [6:0]        MEM_ADDR;
  logic              MEM_WEB;
  logic [NS-1:0]     MEM_CSB;
  logic [NS-1:0]     MEM_OEB;
  logic [7:0]        MEM_IDATA;
  logic [4:0]        MEM_ODATA_SELECT;
  logic              dbg_state;

  spare_remap_ctrl #(.ADDR_W(ADDR_W), .NSPARE(NS)) dut (
    .CLK(CLK), .RSTN(RSTN), .CLR_TABLE(CLR_TABLE),
    .FAULT_VLD(FAULT_VLD), .FAULT_ADDR(FAULT_ADDR), .FAULT_RDY(FAULT_RDY),
    .REQ_VLD(REQ_VLD), .REQ_ADDR(REQ_ADDR), .REQ_WEB(REQ_WEB), .REQ_IDATA(REQ_IDATA),
    .SPARE_HIT(SPARE_HIT), .RD_SPARE_VLD(RD_SPARE_VLD), .USED_CNT(USED_CNT),
    .REPAIR_FAIL(REPAIR_FAIL), .MEM_ADDR(MEM_ADDR), .MEM_WEB(MEM_WEB),
    .MEM_CSB(MEM_CSB), .MEM_OEB(MEM_OEB), .MEM_IDATA(MEM_IDATA),
    .MEM_ODATA_SELECT(MEM_ODATA_SELECT), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- behavioural spare array ----------------
  logic [7:0] sram [NS][128];
  logic [7:0] rq   [NS];
  logic [7:0] odata;

  always @(posedge CLK) begin
    for (int i = 0; i < NS; i++) begin
      if (MEM_CSB[i] == 1'b0) begin
        if (!MEM_WEB) sram[i][MEM_ADDR] <= MEM_IDATA;
        else          rq[i] <= sram[i][MEM_ADDR];
      end
    end
  end

  always_comb begin
    odata = 8'h00;
    if (int'(MEM_ODATA_SELECT) < NS) odata = rq[MEM_ODATA_SELECT];
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int         m_tab[$];      // block index per bank, allocation order
  bit         m_fail, m_pend, m_rdy;
  int         m_pblk;
  logic [NS-1:0] e_csb, e_oeb;
  bit         e_hit, e_web, e_rdv;
  logic [6:0] e_addr;
  logic [7:0] e_idata;
  int         e_sel;
  bit         d_rd;
  int         d_k;
  logic [7:0] ex_mem[int];   // last written byte per full address
  logic [7:0] exp_q[$];
  bit         known_q[$];

  function automatic int lookup(input int blk);
    foreach (m_tab[i]) if (m_tab[i] == blk) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_tab.delete(); m_fail = 0; m_pend = 0; m_rdy = 0; m_pblk = 0;
    e_csb = '1; e_oeb = '1; e_hit = 0; e_web = 1; e_rdv = 0;
    e_addr = '0; e_idata = '0; e_sel = 0; d_rd = 0; d_k = 0;
    ex_mem.delete(); exp_q.delete(); known_q.delete();
  endtask

  // One clock: predict from current inputs, advance, compare everything.
  task automatic step();
    int blk, k;
    bit acc, hit;
    blk = int'(REQ_ADDR[ADDR_W-1:7]);
    k   = lookup(blk);
    acc = FAULT_VLD && m_rdy;
    hit = REQ_VLD && (k >= 0);
    e_rdv = d_rd;
    if (d_rd) begin e_oeb = ~(25'd1 << d_k); e_sel = d_k; end
    else e_oeb = '1;
    if (hit) begin
      e_csb = ~(25'd1 << k); e_hit = 1; e_web = REQ_WEB;
      e_addr = REQ_ADDR[6:0]; e_idata = REQ_IDATA; d_rd = REQ_WEB; d_k = k;
      if (!REQ_WEB) ex_mem[int'(REQ_ADDR)] = REQ_IDATA;
      else if (ex_mem.exists(int'(REQ_ADDR))) begin
        exp_q.push_back(ex_mem[int'(REQ_ADDR)]); known_q.push_back(1'b1);
      end else begin
        exp_q.push_back(8'h00); known_q.push_back(1'b0);
      end
    end else begin
      e_csb = '1; e_hit = 0; e_web = 1; d_rd = 0;
    end
    if (CLR_TABLE) begin
      m_tab.delete(); m_fail = 0; m_pend = 0; ex_mem.delete();
    end else begin
      if (m_pend) begin
        if (lookup(m_pblk) < 0) begin
          if (m_tab.size() < NS) m_tab.push_back(m_pblk);
          else m_fail = 1;
        end
        m_pend = 0;
      end
      if (acc) begin m_pend = 1; m_pblk = int'(FAULT_ADDR[ADDR_W-1:7]); end
    end
    m_rdy = !m_pend;
    @(posedge CLK); #1;
    chk("csb", MEM_CSB, e_csb);
    chk("oeb", MEM_OEB, e_oeb);
    chk("spare_hit", SPARE_HIT, e_hit);
    chk("mem_web", MEM_WEB, e_web);
    chk("mem_addr", MEM_ADDR, e_addr);
    chk("mem_idata", MEM_IDATA, e_idata);
    chk("rd_vld", RD_SPARE_VLD, e_rdv);
    chk("odata_sel", MEM_ODATA_SELECT, e_sel);
    chk("used_cnt", USED_CNT, m_tab.size());
    chk("repair_fail", REPAIR_FAIL, m_fail);
    chk("fault_rdy", FAULT_RDY, m_rdy);
    chk("fsm_busy", dbg_state, m_pend);
    if (RD_SPARE_VLD) begin
      if (exp_q.size() == 0) chk("rd_q_nonempty", 0, 1);
      else begin
        logic [7:0] ev;
        bit kn;
        ev = exp_q.pop_front(); kn = known_q.pop_front();
        if (kn) chk("rd_data", odata, ev);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    CLR_TABLE = 0; FAULT_VLD = 0; FAULT_ADDR = '0;
    REQ_VLD = 0; REQ_ADDR = '0; REQ_WEB = 1; REQ_IDATA = '0;
  endtask

  task automatic idle(input int n);
    REQ_VLD = 0; FAULT_VLD = 0; CLR_TABLE = 0;
    repeat (n) step();
  endtask

  task automatic send_fault(input logic [ADDR_W-1:0] a);
    bit done;
    done = 0;
    FAULT_VLD = 1; FAULT_ADDR = a;
    for (int t = 0; t < 10 && !done; t++) begin
      done = m_rdy;
      step();
    end
    if (!done) chk("fault_accept_timeout", 0, 1);
    FAULT_VLD = 0;
  endtask

  task automatic req(input logic [ADDR_W-1:0] a, input logic web, input logic [7:0] d);
    REQ_VLD = 1; REQ_ADDR = a; REQ_WEB = web; REQ_IDATA = d;
    step();
    REQ_VLD = 0;
  endtask

  task automatic clear_table();
    CLR_TABLE = 1; step(); CLR_TABLE = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    model_reset();
    RSTN = 1;
    #2 RSTN = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_csb", MEM_CSB, 25'h1FFFFFF);
    chk("rst_oeb", MEM_OEB, 25'h1FFFFFF);
    chk("rst_web", MEM_WEB, 1);
    chk("rst_fault_rdy", FAULT_RDY, 0);
    chk("rst_used", USED_CNT, 0);
    chk("rst_fail", REPAIR_FAIL, 0);
    @(negedge CLK) RSTN = 1;
    idle(2);

    // fault 0x0085 (block 1) then read 0x00A3
    send_fault(15'h0085);
    idle(1);
    req(15'h00A3, 1'b1, 8'h00);
    chk("t1_csb", MEM_CSB, 25'h1FFFFFE);
    chk("t1_addr", MEM_ADDR, 7'h23);
    idle(1);
    chk("t1_oeb", MEM_OEB, 25'h1FFFFFE);
    chk("t1_sel", MEM_ODATA_SELECT, 0);
    chk("t1_rdv", RD_SPARE_VLD, 1);

    // duplicate report is dropped; next block goes to bank 1
    clear_table();
    send_fault(15'h0080);
    send_fault(15'h0081);
    send_fault(15'h0100);
    idle(1);
    chk("t2_used", USED_CNT, 2);
    req(15'h0100, 1'b1, 8'h00);
    chk("t2_csb", MEM_CSB, 25'h1FFFFFD);
    idle(1);

    // lookup during the CHECK cycle uses the old table
    send_fault(15'h0280);
    req(15'h0280, 1'b1, 8'h00);
    chk("t3_miss", SPARE_HIT, 0);
    req(15'h0280, 1'b1, 8'h00);
    chk("t3_hit", SPARE_HIT, 1);
    chk("t3_csb", MEM_CSB, 25'h1FFFFFB);
    idle(2);

    // back-to-back write then read of the same address
    req(15'h0285, 1'b0, 8'h55);
    req(15'h0285, 1'b1, 8'h00);
    idle(1);
    chk("t4_rdv", RD_SPARE_VLD, 1);
    chk("t4_sel", MEM_ODATA_SELECT, 2);
    chk("t4_data", odata, 8'h55);
    idle(1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      int blk;
      CLR_TABLE  = ($urandom_range(0, 149) == 0);
      FAULT_VLD  = ($urandom_range(0, 1) == 1);
      FAULT_ADDR = 15'(($urandom_range(0, 35) << 7) | $urandom_range(0, 127));
      REQ_VLD    = ($urandom_range(0, 9) < 8);
      if (m_tab.size() > 0 && $urandom_range(0, 9) < 7)
        blk = m_tab[$urandom_range(0, m_tab.size() - 1)];
      else
        blk = $urandom_range(0, 40);
      REQ_ADDR  = 15'((blk << 7) | $urandom_range(0, 7));
      REQ_WEB   = $urandom_range(0, 1);
      REQ_IDATA = 8'($urandom);
      step();
    end
    idle(3);

    // 26 distinct blocks overflow the table
    clear_table();
    for (int b = 100; b < 126; b++) send_fault(15'(b << 7));
    idle(1);
    chk("t5_used", USED_CNT, 25);
    chk("t5_fail", REPAIR_FAIL, 1);
    req(15'(125 << 7), 1'b1, 8'h00);
    chk("t5_miss", SPARE_HIT, 0);
    req(15'(124 << 7), 1'b1, 8'h00);
    chk("t5_csb24", MEM_CSB, 25'h0FFFFFF);
    idle(2);

    // asynchronous reset while a read is in its data stage
    req(15'(100 << 7), 1'b1, 8'h00);
    idle(1);
    chk("t6_rdv_before", RD_SPARE_VLD, 1);
    #2 RSTN = 0;
    #1;
    chk("t6_csb", MEM_CSB, 25'h1FFFFFF);
    chk("t6_oeb", MEM_OEB, 25'h1FFFFFF);
    chk("t6_used", USED_CNT, 0);
    chk("t6_rdv", RD_SPARE_VLD, 0);
    model_reset();
    idle_inputs();
    @(negedge CLK) RSTN = 1;
    req(15'(100 << 7), 1'b1, 8'h00);
    chk("t6_no_hit", SPARE_HIT, 0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
